axil_uart_tx_fifo: RTL and testbench

- AXI4-Lite slave that buffers bytes written by the CPU in a TX FIFO and drains them into the simpleuart data-register interface.
- Sits directly upstream of simpleuart, between the interconnect and the UART, on the SoC bus.
- Lets software queue up to DEPTH bytes without stalling on the UART's busy wait.
- Exposes a status register giving FIFO level, full/empty flags and a sticky overflow flag.

---
 rtl/axil_uart_tx_fifo.sv | 172 +++++++++++++++++
 tb/tb_axil_uart_tx_fifo.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_uart_tx_fifo.sv
// AXI4-Lite TX FIFO in front of simpleuart: CPU writes bytes to TXDATA, a drain FSM feeds the UART.
// Optional build macro UART_TXF_IRQ_EN adds the irq output and the STATUS.irq_en bit.
module axil_uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_wvalid,
  output logic              s_wready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  output logic              s_bvalid,
  input  logic              s_bready,
  output logic [1:0]        s_bresp,
  input  logic              s_arvalid,
  output logic              s_arready,
  input  logic [ADDR_W-1:0] s_araddr,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              uart_dat_we,
  output logic [7:0]        uart_dat_di,
`ifdef UART_TXF_IRQ_EN
  output logic              irq,
`endif
  input  logic              uart_dat_wait
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_L = PW'(DEPTH);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic {IDLE, SEND} st_t;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wptr, rptr, level;
  logic          full, empty, ovf, irq_en;
  logic          wr_hs, rd_hs, push, pop, wr_ovf, ovf_clr;
  logic [1:0]    wsel, rsel, bresp_d, rresp_d;
  logic [31:0]   status, rdata_d;
  logic [7:0]    head, di_q;
  st_t           state, nxt;

  assign level = wptr - rptr;
  assign full  = (level == DEPTH_L);
  assign empty = (level == '0);
  assign head  = mem[rptr[AW-1:0]];

  // AW and W are only ever taken together, so one register drives both readies
  assign s_wready = s_awready;
  assign wr_hs    = s_awready && s_awvalid && s_wvalid;
  assign rd_hs    = s_arready && s_arvalid;
  assign wsel     = s_awaddr[3:2];
  assign rsel     = s_araddr[3:2];

  assign push    = wr_hs && (wsel == 2'd0) && s_wstrb[0] && !full;
  assign wr_ovf  = wr_hs && (wsel == 2'd0) && s_wstrb[0] && full;
  assign ovf_clr = wr_hs && (wsel == 2'd1) && s_wstrb[2] && s_wdata[16];
  assign pop     = (state == SEND) && !uart_dat_wait;

  assign bresp_d = (wsel[1] || wr_ovf) ? SLVERR : OKAY;
  assign status  = {14'd0, irq_en, ovf, 8'(level), 6'd0, full, empty};

  always_comb begin
    rdata_d = '0;
    rresp_d = OKAY;
    case (rsel)
      2'd0:    rdata_d = '0;
      2'd1:    rdata_d = status;
      default: rresp_d = SLVERR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_awready <= 1'b0;
      s_bvalid  <= 1'b0;
      s_bresp   <= OKAY;
      s_arready <= 1'b0;
      s_rvalid  <= 1'b0;
      s_rdata   <= '0;
      s_rresp   <= OKAY;
    end else begin
      s_awready <= !s_awready && s_awvalid && s_wvalid && !s_bvalid;
      s_arready <= !s_arready && s_arvalid && !s_rvalid;
      if (wr_hs) begin
        s_bvalid <= 1'b1;
        s_bresp  <= bresp_d;
      end else if (s_bvalid && s_bready) begin
        s_bvalid <= 1'b0;
        s_bresp  <= OKAY;
      end
      if (rd_hs) begin
        s_rvalid <= 1'b1;
        s_rdata  <= rdata_d;
        s_rresp  <= rresp_d;
      end else if (s_rvalid && s_rready) begin
        s_rvalid <= 1'b0;
        s_rdata  <= '0;
        s_rresp  <= OKAY;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      ovf  <= 1'b0;
    end else begin
      if (push)         wptr <= wptr + PW'(1);
      if (pop)          rptr <= rptr + PW'(1);
      if (wr_ovf)       ovf  <= 1'b1;
      else if (ovf_clr) ovf  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= s_wdata[7:0];
  end

`ifdef UART_TXF_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr_hs && (wsel == 2'd1) && s_wstrb[2]) irq_en <= s_wdata[17];
      irq <= irq_en && (level <= PW'(DEPTH / 4));
    end
  end
`else
  assign irq_en = 1'b0;
`endif

  // drain FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (!empty) nxt = SEND;
      SEND:    if (pop && (level == PW'(1)) && !push) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    uart_dat_we = (state == SEND);
    uart_dat_di = (state == SEND) ? head : di_q;
  end

  // keeps the last byte on the data lines while idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              di_q <= '0;
    else if (state == SEND) di_q <= head;
  end

  logic unused_bits;
  assign unused_bits = &{1'b0, s_awaddr, s_araddr, s_wdata, s_wstrb};

endmodule

// File: tb/tb_axil_uart_tx_fifo.sv
// Scoreboard bench for axil_uart_tx_fifo: directed AXI-Lite traffic, monitors check B, R and UART bytes.
module tb_axil_uart_tx_fifo;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        clk = 1'b0, reset = 1'b1;
  logic        s_awvalid = 0, s_awready, s_wvalid = 0, s_wready;
  logic [3:0]  s_awaddr = 0, s_araddr = 0, s_wstrb = 0;
  logic [31:0] s_wdata = 0, s_rdata;
  logic        s_bvalid, s_bready = 1, s_arvalid = 0, s_arready, s_rvalid, s_rready = 1;
  logic [1:0]  s_bresp, s_rresp;
  logic        uart_dat_we, uart_dat_wait = 0;
  logic [7:0]  uart_dat_di;
`ifdef UART_TXF_IRQ_EN
  logic        irq;
  localparam logic [31:0] IRQB = 32'h0002_0000;
`else
  localparam logic [31:0] IRQB = 32'h0;
`endif

  int n_chk = 0, n_fail = 0;
  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];
  logic [7:0]  exp_uart[$];

  axil_uart_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .uart_dat_we(uart_dat_we), .uart_dat_di(uart_dat_di),
`ifdef UART_TXF_IRQ_EN
    .irq(irq),
`endif
    .uart_dat_wait(uart_dat_wait)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // monitors: sample on the falling edge, pop the scoreboard on every completed transfer
  always @(negedge clk) if (!reset && s_bvalid && s_bready) begin
    if (exp_b.size() == 0) check("bresp_unexpected", 64'(s_bresp), 64'hdead);
    else check("bresp", 64'(s_bresp), 64'(exp_b.pop_front()));
  end

  always @(negedge clk) if (!reset && s_rvalid && s_rready) begin
    if (exp_r.size() == 0) check("rdata_unexpected", 64'({s_rresp, s_rdata}), 64'hdead);
    else check("rresp_rdata", 64'({s_rresp, s_rdata}), 64'(exp_r.pop_front()));
  end

  always @(negedge clk) if (!reset && uart_dat_we && !uart_dat_wait) begin
    if (exp_uart.size() == 0) check("uart_unexpected", 64'(uart_dat_di), 64'hdead);
    else check("uart_byte", 64'(uart_dat_di), 64'(exp_uart.pop_front()));
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_aw(input logic [3:0] a, input logic [31:0] d, input logic [3:0] st,
                          input logic [1:0] er);
    exp_b.push_back(er);
    s_awaddr = a; s_wdata = d; s_wstrb = st; s_awvalid = 1; s_wvalid = 1;
  endtask

  task automatic wait_aw();
    bit ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (s_awready) ok = 1;
    end
    @(posedge clk); #1;
    s_awvalid = 0; s_wvalid = 0;
    if (!ok) check("aw_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_b();
    bit ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (s_bvalid && s_bready) ok = 1;
    end
    @(posedge clk); #1;
    if (!ok) check("b_timeout", 64'd0, 64'd1);
  endtask

  task automatic axi_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] st,
                        input logic [1:0] er);
    drive_aw(a, d, st, er);
    wait_aw();
    wait_b();
  endtask

  task automatic axi_rd(input logic [3:0] a, input logic [31:0] ed, input logic [1:0] er);
    bit ok = 0;
    exp_r.push_back({er, ed});
    s_araddr = a; s_arvalid = 1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (s_arready) ok = 1;
    end
    @(posedge clk); #1;
    s_arvalid = 0;
    if (!ok) check("ar_timeout", 64'd0, 64'd1);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (s_rvalid && s_rready) ok = 1;
    end
    @(posedge clk); #1;
    if (!ok) check("r_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [63:0] outs();
    return 64'({s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rresp,
                s_rdata, uart_dat_we, uart_dat_di});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state and empty STATUS
    #2 check("reset_outputs", outs(), 64'd0);
`ifdef UART_TXF_IRQ_EN
    check("reset_irq", 64'(irq), 64'd0);
`endif
    tick(2);
    reset = 0;
    tick(1);
    axi_rd(4'h4, 32'h1, OKAY);
    check("idle_we", 64'(uart_dat_we), 64'd0);

    // 2: three bytes in order; first one checks push-to-we latency
    exp_uart.push_back(8'h41);
    drive_aw(4'h0, 32'h41, 4'hF, OKAY);
    wait_aw();
    check("lat_we_n1", 64'(uart_dat_we), 64'd0);
    tick(1);
    check("lat_we_n2", 64'(uart_dat_we), 64'd1);
    tick(1);
    exp_uart.push_back(8'h42); axi_wr(4'h0, 32'h42, 4'hF, OKAY);
    exp_uart.push_back(8'h43); axi_wr(4'h0, 32'h43, 4'hF, OKAY);
    axi_wr(4'h0, 32'h99, 4'hE, OKAY);
    tick(5);
    axi_rd(4'h4, 32'h1, OKAY);
    axi_wr(4'h4, 32'h0002_0000, 4'hF, OKAY);
    axi_rd(4'h4, 32'h1 | IRQB, OKAY);
    axi_wr(4'h4, 32'h0, 4'hF, OKAY);

    // 3: fill to full with the UART stalled, overflow, clear overflow
    uart_dat_wait = 1;
    for (int i = 0; i < 16; i++) begin
      exp_uart.push_back(8'(8'h50 + i));
      axi_wr(4'h0, 32'(8'h50 + i), 4'hF, OKAY);
    end
    axi_wr(4'h0, 32'h60, 4'hF, SLVERR);
    axi_rd(4'h4, 32'h0001_1002, OKAY);
    axi_wr(4'h4, 32'h0001_0000, 4'hF, OKAY);
    axi_rd(4'h4, 32'h0000_1002, OKAY);

    // 4: write while full coinciding with a pop is rejected; refill; three rounds
    for (int k = 0; k < 3; k++) begin
      drive_aw(4'h0, 32'(8'h70 + k), 4'hF, SLVERR);
      tick(1);
      check("t4_aw_align", 64'(s_awready), 64'd1);
      uart_dat_wait = 0;
      tick(1);
      uart_dat_wait = 1; s_awvalid = 0; s_wvalid = 0;
      wait_b();
      axi_rd(4'h4, 32'h0001_0F00, OKAY);
      exp_uart.push_back(8'(8'h80 + k));
      axi_wr(4'h0, 32'(8'h80 + k), 4'hF, OKAY);
    end
    axi_rd(4'h4, 32'h0001_1002, OKAY);
    uart_dat_wait = 0;
    for (int i = 0; i < 200 && exp_uart.size() != 0; i++) tick(1);
    check("t4_drained", 64'(exp_uart.size()), 64'd0);
    tick(3);
    axi_wr(4'h4, 32'h0001_0000, 4'hF, OKAY);
    axi_rd(4'h4, 32'h1, OKAY);
    for (int i = 0; i < 12; i++) begin
      exp_uart.push_back(8'(8'hA0 + i));
      axi_wr(4'h0, 32'(8'hA0 + i), 4'hF, OKAY);
    end
    tick(5);
    axi_rd(4'h4, 32'h1, OKAY);

    // 5: asynchronous reset while sending, level 5, B pending
    uart_dat_wait = 1;
    for (int i = 0; i < 4; i++) begin
      exp_uart.push_back(8'(8'hB0 + i));
      axi_wr(4'h0, 32'(8'hB0 + i), 4'hF, OKAY);
    end
    s_bready = 0;
    exp_uart.push_back(8'hB4);
    drive_aw(4'h0, 32'hB4, 4'hF, OKAY);
    wait_aw();
    tick(2);
    check("t5_pre_bvalid", 64'(s_bvalid), 64'd1);
    check("t5_pre_we", 64'(uart_dat_we), 64'd1);
    #2 reset = 1;
    #1 check("t5_reset_outputs", outs(), 64'd0);
    exp_b.delete(); exp_uart.delete();
    tick(2);
    reset = 0; s_bready = 1; uart_dat_wait = 0;
    tick(1);
    axi_rd(4'h4, 32'h1, OKAY);
    check("t5_post_we", 64'(uart_dat_we), 64'd0);

    // 6: B held off, second write blocked; unmapped addresses
    s_bready = 0;
    exp_uart.push_back(8'h77);
    drive_aw(4'h0, 32'h77, 4'hF, OKAY);
    wait_aw();
    drive_aw(4'hC, 32'h1234, 4'hF, SLVERR);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("t6_bvalid_hold", 64'({s_bvalid, s_bresp}), 64'({1'b1, OKAY}));
      check("t6_aw_blocked", 64'(s_awready), 64'd0);
    end
    s_bready = 1;
    wait_aw();
    wait_b();
    axi_rd(4'hC, 32'h0, SLVERR);
    axi_rd(4'h8, 32'h0, SLVERR);
    axi_rd(4'h0, 32'h0, OKAY);
    tick(5);
    axi_rd(4'h4, 32'h1, OKAY);

    tick(3);
    check("end_exp_b", 64'(exp_b.size()), 64'd0);
    check("end_exp_r", 64'(exp_r.size()), 64'd0);
    check("end_exp_uart", 64'(exp_uart.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
